// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: loads a program into an external word
// memory, then fetches sequentially into a 2-entry queue toward decode.
// Handles branch redirects with a one-cycle bubble and halts on fetch faults.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        load_en,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  output logic        load_ready,
  input  logic        load_done,
  output logic        mem_we,
  output logic [7:0]  mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready,
  output logic [1:0]  state,
  output logic [8:0]  prog_len,
  output logic        fault
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  localparam logic [8:0] MEM_WORDS_C = 9'(MEM_WORDS);

  // Control state
  state_e      state_q;
  logic [31:0] pc_q;
  logic [8:0]  load_cnt_q;
  logic [8:0]  prog_len_q;
  logic        fault_q;

  // Fetch queue: slot 0 is always the head, slot 1 the tail
  logic [31:0] head_pc_q,    head_pc_d;
  logic [31:0] head_instr_q, head_instr_d;
  logic [31:0] tail_pc_q,    tail_pc_d;
  logic [31:0] tail_instr_q, tail_instr_d;
  logic [1:0]  fifo_cnt_q,   fifo_cnt_d;

  // Per-cycle decisions
  logic in_run_s;
  logic load_ready_s;
  logic load_acc_s;
  logic fifo_full_s;
  logic fifo_empty_s;
  logic pop_s;
  logic can_enq_s;
  logic redir_fault_s;
  logic pc_fault_s;
  logic enq_s;
  logic flush_s;

  assign in_run_s     = (state_q == ST_RUN);
  assign load_ready_s = (state_q == ST_LOAD) && (load_cnt_q < MEM_WORDS_C);
  assign load_acc_s   = load_valid && load_ready_s;
  assign fifo_full_s  = (fifo_cnt_q == 2'd2);
  assign fifo_empty_s = (fifo_cnt_q == 2'd0);
  assign pop_s        = in_run_s && !fifo_empty_s && if_ready;
  // A full queue can still take a word when its head leaves this cycle
  assign can_enq_s    = !fifo_full_s || pop_s;
  assign redir_fault_s = in_run_s && redirect_valid && (redirect_pc[1:0] != 2'b00);
  // Only a fetch that would actually happen can fault on an out-of-range pc
  assign pc_fault_s   = in_run_s && !redirect_valid && can_enq_s && (pc_q[31:10] != 22'd0);
  assign enq_s        = in_run_s && !redirect_valid && can_enq_s && !pc_fault_s;
  // Any redirect (good or bad) and any fetch fault discard queued words
  assign flush_s      = in_run_s && (redirect_valid || pc_fault_s);

  // Control FSM: mode transitions, pc sequencing, load counting and fault capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      load_cnt_q <= 9'd0;
      prog_len_q <= 9'd0;
      fault_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_en) begin
            state_q    <= ST_LOAD;
            load_cnt_q <= 9'd0;
          end else if (start && (prog_len_q != 9'd0)) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (load_acc_s) begin
            load_cnt_q <= load_cnt_q + 9'd1;
          end
          if (load_done) begin
            // A word accepted alongside load_done still belongs to the program
            prog_len_q <= load_cnt_q + {8'd0, load_acc_s};
            state_q    <= ST_IDLE;
          end else begin
            state_q <= ST_LOAD;
          end
        end
        ST_RUN: begin
          if (redir_fault_s || pc_fault_s) begin
            fault_q <= 1'b1;
            state_q <= ST_HALT;
          end else if (redirect_valid) begin
            pc_q <= redirect_pc;
          end else if (enq_s) begin
            pc_q <= pc_q + 32'd4;
          end else begin
            pc_q <= pc_q;
          end
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Queue next-state: flush, pop-shift, enqueue into first free slot
  always_comb begin
    fifo_cnt_d   = fifo_cnt_q;
    head_pc_d    = head_pc_q;
    head_instr_d = head_instr_q;
    tail_pc_d    = tail_pc_q;
    tail_instr_d = tail_instr_q;
    if (flush_s) begin
      fifo_cnt_d = 2'd0;
    end else begin
      case ({pop_s, enq_s})
        2'b10: begin
          head_pc_d    = tail_pc_q;
          head_instr_d = tail_instr_q;
          fifo_cnt_d   = fifo_cnt_q - 2'd1;
        end
        2'b01: begin
          if (fifo_cnt_q == 2'd0) begin
            head_pc_d    = pc_q;
            head_instr_d = mem_rdata;
          end else begin
            tail_pc_d    = pc_q;
            tail_instr_d = mem_rdata;
          end
          fifo_cnt_d = fifo_cnt_q + 2'd1;
        end
        2'b11: begin
          if (fifo_cnt_q == 2'd2) begin
            head_pc_d    = tail_pc_q;
            head_instr_d = tail_instr_q;
            tail_pc_d    = pc_q;
            tail_instr_d = mem_rdata;
          end else begin
            head_pc_d    = pc_q;
            head_instr_d = mem_rdata;
          end
        end
        default: begin
          fifo_cnt_d = fifo_cnt_q;
        end
      endcase
    end
  end

  // Queue storage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_cnt_q   <= 2'd0;
      head_pc_q    <= 32'd0;
      head_instr_q <= 32'd0;
      tail_pc_q    <= 32'd0;
      tail_instr_q <= 32'd0;
    end else begin
      fifo_cnt_q   <= fifo_cnt_d;
      head_pc_q    <= head_pc_d;
      head_instr_q <= head_instr_d;
      tail_pc_q    <= tail_pc_d;
      tail_instr_q <= tail_instr_d;
    end
  end

  assign load_ready = load_ready_s;
  assign mem_we     = load_acc_s;
  assign mem_waddr  = load_cnt_q[7:0];
  assign mem_wdata  = load_data;
  assign mem_addr   = pc_q;
  assign if_valid   = in_run_s && !fifo_empty_s;
  assign if_instr   = head_instr_q;
  assign if_pc      = head_pc_q;
  assign state      = state_q;
  assign prog_len   = prog_len_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: queue-based reference model checked every
// cycle, plus hand-computed expectations for the key scenarios.
module tb_instr_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        load_en;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_ready;
  logic        load_done;
  logic        mem_we;
  logic [7:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic [1:0]  state;
  logic [8:0]  prog_len;
  logic        fault;

  instr_fetch_ctrl #(.RESET_PC(RESET_PC), .MEM_WORDS(256)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_en(load_en),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .load_done(load_done), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_ready(if_ready), .state(state), .prog_len(prog_len), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory seen by the DUT
  logic [31:0] mem [256];
  always @(posedge clk) if (mem_we) mem[mem_waddr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr[9:2]];

  // Reference model
  typedef struct packed { logic [31:0] pc; logic [31:0] ins; } ent_t;
  logic [31:0] exp_prog [256];
  ent_t        mq [$];
  int          m_st;
  logic [31:0] m_pc;
  int          m_cnt;
  int          m_len;
  bit          m_fault;

  int n_checks = 0;
  int n_err    = 0;
  int we_cnt   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One cycle: compare DUT against model, advance model, cross one clock
  task automatic step();
    bit   e_v, e_lr, e_we, pop, room;
    ent_t dummy;
    #1;
    e_v  = mq.size() > 0;
    e_lr = (m_st == 1) && (m_cnt < 256);
    e_we = e_lr && load_valid;
    chk("state", 32'(state), 32'(m_st));
    chk("if_valid", 32'(if_valid), 32'(e_v));
    if (e_v) begin
      chk("if_pc", if_pc, mq[0].pc);
      chk("if_instr", if_instr, mq[0].ins);
    end
    chk("mem_addr", mem_addr, m_pc);
    chk("load_ready", 32'(load_ready), 32'(e_lr));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    if (e_we) begin
      chk("mem_waddr", 32'(mem_waddr), 32'(m_cnt % 256));
      chk("mem_wdata", mem_wdata, load_data);
    end
    chk("prog_len", 32'(prog_len), 32'(m_len));
    chk("fault", 32'(fault), 32'(m_fault));
    if (mem_we) we_cnt++;

    case (m_st)
      0: begin
        if (load_en) begin m_st = 1; m_cnt = 0; end
        else if (start && m_len != 0) begin m_st = 2; m_pc = RESET_PC; end
      end
      1: begin
        if (load_valid && m_cnt < 256) begin exp_prog[m_cnt] = load_data; m_cnt++; end
        if (load_done) begin m_len = m_cnt; m_st = 0; end
      end
      2: begin
        pop = (mq.size() > 0) && if_ready;
        if (redirect_valid) begin
          mq.delete();
          if (redirect_pc[1:0] != 2'b00) begin m_fault = 1; m_st = 3; end
          else m_pc = redirect_pc;
        end else begin
          room = (mq.size() < 2) || pop;
          if (pop) dummy = mq.pop_front();
          if (room) begin
            if (m_pc >= 32'd1024) begin m_fault = 1; m_st = 3; mq.delete(); end
            else begin
              mq.push_back('{pc: m_pc, ins: exp_prog[m_pc[9:2]]});
              m_pc = m_pc + 32'd4;
            end
          end
        end
      end
      default: ;
    endcase
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic inputs_idle();
    start = 0; load_en = 0; load_valid = 0; load_data = 0; load_done = 0;
    redirect_valid = 0; redirect_pc = 0; if_ready = 0;
  endtask

  // Asynchronous reset mid-cycle: outputs must clear before any clock edge
  task automatic do_reset();
    #2 rst_n = 0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_prog_len", 32'(prog_len), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_load_ready", 32'(load_ready), 32'd0);
    chk("rst_mem_addr", mem_addr, RESET_PC);
    inputs_idle();
    m_st = 0; m_pc = RESET_PC; m_cnt = 0; m_len = 0; m_fault = 0; mq.delete();
    @(negedge clk);
    rst_n = 1;
  endtask

  logic [31:0] prog4 [4];
  logic [31:0] seen_pc [5];
  logic [31:0] seen_in [5];
  int edges;

  initial begin
    prog4[0] = 32'h00500093; prog4[1] = 32'h00A00113;
    prog4[2] = 32'h002081B3; prog4[3] = 32'h0000006F;
    for (int i = 0; i < 256; i++) begin mem[i] = 32'd0; exp_prog[i] = 32'd0; end
    rst_n = 0;
    inputs_idle();
    do_reset();

    // Load four words, then load_done
    load_en = 1; step(); load_en = 0;
    we_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      load_valid = 1; load_data = prog4[i]; step();
    end
    load_valid = 0; load_done = 1; step(); load_done = 0;
    chk("load4_we_count", 32'(we_cnt), 32'd4);
    chk("load4_prog_len", 32'(prog_len), 32'd4);
    chk("load4_state_idle", 32'(state), 32'd0);

    // Start with decode always ready: latency and sequential pcs
    if_ready = 1; start = 1; step(); start = 0; edges = 1;
    while (if_valid !== 1'b1 && edges < 10) begin step(); edges++; end
    chk("start_latency_edges", 32'(edges), 32'd2);
    for (int i = 0; i < 5; i++) begin
      seen_pc[i] = if_pc; seen_in[i] = if_instr; step();
    end
    for (int i = 0; i < 5; i++) chk("seq_pc", seen_pc[i], 32'(4 * i));
    chk("seq_instr0", seen_in[0], 32'h00500093);
    chk("seq_instr2", seen_in[2], 32'h002081B3);
    chk("seq_instr4", seen_in[4], 32'h00000000);

    // Restart at 0 with decode stalled for five cycles
    redirect_valid = 1; redirect_pc = 32'h0; if_ready = 0; step();
    redirect_valid = 0;
    repeat (5) step();
    #1;
    chk("stall_mem_addr", mem_addr, 32'h8);
    chk("stall_if_pc", if_pc, 32'h0);
    chk("stall_if_valid", 32'(if_valid), 32'd1);
    if_ready = 1;
    for (int i = 0; i < 3; i++) begin seen_pc[i] = if_pc; step(); end
    chk("drain_pc0", seen_pc[0], 32'h0);
    chk("drain_pc1", seen_pc[1], 32'h4);
    chk("drain_pc2", seen_pc[2], 32'h8);

    // Redirect to 0x8 while a word is being consumed
    redirect_valid = 1; redirect_pc = 32'h8; step(); redirect_valid = 0;
    chk("redir_bubble", 32'(if_valid), 32'd0);
    step();
    chk("redir_valid", 32'(if_valid), 32'd1);
    chk("redir_if_pc", if_pc, 32'h8);
    chk("redir_if_instr", if_instr, 32'h002081B3);

    // Misaligned redirect faults and halts; inputs afterwards are ignored
    redirect_valid = 1; redirect_pc = 32'h6; step(); redirect_valid = 0;
    chk("halt_fault", 32'(fault), 32'd1);
    chk("halt_state", 32'(state), 32'd3);
    chk("halt_if_valid", 32'(if_valid), 32'd0);
    start = 1; load_en = 1; load_valid = 1; redirect_valid = 1; redirect_pc = 32'h0;
    repeat (3) step();
    inputs_idle();
    chk("halt_sticky_state", 32'(state), 32'd3);
    chk("halt_sticky_fault", 32'(fault), 32'd1);
    do_reset();

    // Empty program: start ignored
    start = 1; step(); start = 0; step();
    chk("empty_start_idle", 32'(state), 32'd0);

    // Offer 260 words: only 256 accepted
    load_en = 1; step(); load_en = 0;
    we_cnt = 0;
    for (int i = 0; i < 260; i++) begin
      load_valid = 1; load_data = 32'hA500_0000 + 32'(i * 7); step();
    end
    chk("full_load_ready_low", 32'(load_ready), 32'd0);
    load_valid = 0; load_done = 1; step(); load_done = 0;
    chk("full_we_count", 32'(we_cnt), 32'd256);
    chk("full_prog_len", 32'(prog_len), 32'd256);

    // Run with an irregular decode pattern, then reset mid-run
    start = 1; step(); start = 0;
    for (int i = 0; i < 8; i++) begin if_ready = (i % 3) != 0; step(); end
    do_reset();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset and on each start.
REQ-002 SHALL provide parameter MEM_WORDS, default 256, meaning the instruction memory depth in words; the word index is address[9:2].
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning the asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, meaning a request to begin fetching from RESET_PC.
REQ-006 SHALL have port load_en, input, 1, meaning a request to enter program-load mode.
REQ-007 SHALL have ports load_valid (input, 1), load_data (input, 32) and load_ready (output, 1), meaning the loader word stream handshake.
REQ-008 SHALL have port load_done, input, 1, meaning the end of the loaded program.
REQ-009 SHALL have ports mem_we (output, 1), mem_waddr (output, 8) and mem_wdata (output, 32), meaning the memory write port.
REQ-010 SHALL have ports mem_addr (output, 32, byte address) and mem_rdata (input, 32, combinational read data), meaning the memory read port.
REQ-011 SHALL have ports redirect_valid (input, 1) and redirect_pc (input, 32), meaning a branch or jump target.
REQ-012 SHALL have ports if_valid (output, 1), if_instr (output, 32), if_pc (output, 32) and if_ready (input, 1), meaning the decode-side handshake.
REQ-013 SHALL have ports state (output, 2), prog_len (output, 9) and fault (output, 1), meaning status.

Function
REQ-014 SHALL use an FSM with states IDLE=0, LOAD=1, RUN=2 and HALT=3, and drive state with the current state.
REQ-015 IDLE: load_en SHALL go to LOAD; otherwise start SHALL go to RUN with pc=RESET_PC; if both are high, load_en SHALL win.
REQ-016 LOAD: load_ready SHALL equal (load_cnt < MEM_WORDS).
REQ-017 LOAD: each load_valid&&load_ready cycle SHALL assert mem_we in the same cycle, with mem_waddr=load_cnt[7:0] and mem_wdata=load_data, and SHALL increment load_cnt.
REQ-018 LOAD: load_cnt SHALL saturate at 256, and words offered while load_ready is low SHALL be dropped.
REQ-019 LOAD: load_done SHALL set prog_len=load_cnt (including any word accepted that cycle) and go to IDLE.
REQ-020 mem_we SHALL be 0 in every state other than LOAD.
REQ-021 RUN: mem_addr SHALL equal pc.
REQ-022 RUN: when the 2-entry FIFO is not full, or is full and is being popped this cycle, and there is no redirect, the block SHALL enqueue {pc, mem_rdata} and set pc<=pc+4 (32-bit wrap).
REQ-023 if_valid SHALL equal FIFO non-empty, and if_instr/if_pc SHALL show the head entry; a pop SHALL occur on if_valid&&if_ready.
REQ-024 Latency: start sampled at edge N SHALL enter RUN at N; the first fetch SHALL occur in cycle N..N+1; if_valid SHALL rise after edge N+1.
REQ-025 A redirect_valid sampled in RUN SHALL flush the FIFO (the popped head is discarded), set pc<=redirect_pc and block enqueue that cycle; if_valid SHALL return one edge later, giving a one-cycle bubble.
REQ-026 Redirect SHALL take priority over a simultaneous pop and a simultaneous enqueue.
REQ-027 A redirect_pc[1:0]!=0, or a fetch pc with pc[31:10]!=0, SHALL set fault (sticky), flush the FIFO and go to HALT.
REQ-028 HALT SHALL hold if_valid=0 and ignore all inputs until reset.
REQ-029 When prog_len=0, start SHALL be ignored and the FSM SHALL remain in IDLE.
REQ-030 In IDLE, LOAD and HALT, if_valid SHALL be 0 and mem_addr SHALL equal pc.

Reset
REQ-031 Asserting rst_n=0 SHALL immediately and asynchronously set state=IDLE, pc=RESET_PC, load_cnt=0, prog_len=0, fault=0, an empty FIFO, and if_valid=mem_we=load_ready=0.
REQ-032 if_instr and if_pc SHALL read 0 during reset.
REQ-033 Reset asserted mid-LOAD SHALL discard prog_len; already-written memory words are not cleared.
REQ-034 Reset release SHALL take effect at the first rising edge with rst_n=1.

Verification
REQ-035 Load 4 words 0x00500093, 0x00A00113, 0x002081B3, 0x0000006F then load_done -> mem_we pulses with addresses 0..3 and prog_len=4.
REQ-036 start with if_ready=1 -> if_valid rises 2 edges after start, then shows pc 0,4,8,12,16... one per cycle with matching instructions.
REQ-037 Hold if_ready=0 for 5 cycles in RUN -> FIFO fills at 2 entries, pc stalls at 8, if_pc holds 0; release -> pc 0,4,8 delivered in order with no loss.
REQ-038 redirect_pc=0x8 while if_valid=1, if_ready=1 -> head discarded, one bubble, next if_pc=0x8.
REQ-039 redirect_pc=0x6 -> fault=1, state=HALT, if_valid=0 until rst_n pulse.
REQ-040 Offer 260 words in LOAD -> 256 mem_we pulses, load_ready low after the 256th, prog_len=256; rst_n low mid-RUN -> all outputs return to reset values immediately.
